// File: rtl/accel_pkg.sv
// Shared definitions for the inference scheduler slice.
//   IP_ADDR_WIDTH / MAC_ADDR_WIDTH / TAG_WIDTH : requester address and job tag widths
//   sched_state_t : scheduler FSM state encoding
//   job_addr_t    : per-slot routing info (who asked, and which job it was)
package accel_pkg;

    localparam int IP_ADDR_WIDTH  = 32;
    localparam int MAC_ADDR_WIDTH = 48;
    localparam int TAG_WIDTH      = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_ACC = 3'd1,
        WAIT_ACC  = 3'd2,
        TX_REQ    = 3'd3,
        WAIT_TX   = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [IP_ADDR_WIDTH-1:0]  ip;
        logic [MAC_ADDR_WIDTH-1:0] mac;
        logic [TAG_WIDTH-1:0]      tag;
    } job_addr_t;

endpackage

// File: rtl/inference_scheduler_if.sv
// Response-request channel between the scheduler and the transmitter.
//   TX_VALID/TX_READY : request handshake, fields qualified by TX_VALID
//   TX_DST_IP/TX_DST_MAC/TX_TAG/TX_RESULT/TX_TIMEOUT : response fields
//   TX_DONE : transmitter finished sending the response (single-cycle pulse)
// master = scheduler side, slave = transmitter side.
interface inference_scheduler_if #(
    parameter int RESULT_WIDTH = 8
);
    logic                                  TX_VALID;
    logic                                  TX_READY;
    logic [accel_pkg::IP_ADDR_WIDTH-1:0]   TX_DST_IP;
    logic [accel_pkg::MAC_ADDR_WIDTH-1:0]  TX_DST_MAC;
    logic [accel_pkg::TAG_WIDTH-1:0]       TX_TAG;
    logic [RESULT_WIDTH-1:0]               TX_RESULT;
    logic                                  TX_TIMEOUT;
    logic                                  TX_DONE;

    modport master (
        output TX_VALID, TX_DST_IP, TX_DST_MAC, TX_TAG, TX_RESULT, TX_TIMEOUT,
        input  TX_READY, TX_DONE
    );

    modport slave (
        input  TX_VALID, TX_DST_IP, TX_DST_MAC, TX_TAG, TX_RESULT, TX_TIMEOUT,
        output TX_READY, TX_DONE
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
//   ACLK, ARESET (async, active-low) ; inc_i : increment request ; count_o : count
module sat_counter #(
    parameter int SIZE = 16
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            inc_i,
    output logic [SIZE-1:0] count_o
);

    logic [SIZE-1:0] count_q;
    logic [SIZE-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/inference_scheduler.sv
// Inference job scheduler: takes parsed request frames, runs them one at a time
// on the accelerator and hands each result to the transmitter.
// One active job slot plus one pending slot; further requests are dropped and counted.
// Ports:
//   ACLK, ARESET (async, active-low)
//   RX_DATA_FRAME/RX_SRC_IP/RX_SRC_MAC/RX_FRAME_READY : incoming request (byte 0 = tag)
//   ACC_FRAME/ACC_START/ACC_DONE/ACC_RESULT           : accelerator side
//   tx (inference_scheduler_if.master)                : response request to transmitter
//   BUSY : state not IDLE ; DROP_COUNT : saturating dropped-frame count
// Build option: define INFERENCE_SCHEDULER_TIMEOUT_EN to compile in the accelerator
// watchdog (TIMEOUT_CYCLES cycles in WAIT_ACC without ACC_DONE -> timed-out response).
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no job; active and pending slots empty
// START_ACC | active slot loaded, ACC_START issued on leaving
// WAIT_ACC  | accelerator running the active job
// TX_REQ    | TX_VALID high, waiting for TX_READY
// WAIT_TX   | transmitter sending; TX_DONE retires the active job
module inference_scheduler
    import accel_pkg::*;
#(
    parameter int USER_DATA_BYTES = 785,
    parameter int RESULT_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [USER_DATA_BYTES*8-1:0]     RX_DATA_FRAME,
    input  logic [IP_ADDR_WIDTH-1:0]         RX_SRC_IP,
    input  logic [MAC_ADDR_WIDTH-1:0]        RX_SRC_MAC,
    input  logic                             RX_FRAME_READY,
    output logic [(USER_DATA_BYTES-1)*8-1:0] ACC_FRAME,
    output logic                             ACC_START,
    input  logic                             ACC_DONE,
    input  logic [RESULT_WIDTH-1:0]          ACC_RESULT,
    inference_scheduler_if.master            tx,
    output logic                             BUSY,
    output logic [15:0]                      DROP_COUNT
);

    localparam int PAYLOAD_W = (USER_DATA_BYTES - 1) * 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("inference_scheduler: TIMEOUT_CYCLES must be at least 1");
    end

    sched_state_t          state_q;
    logic [PAYLOAD_W-1:0]  act_frame_q;
    job_addr_t             act_addr_q;
    logic [PAYLOAD_W-1:0]  pend_frame_q;
    job_addr_t             pend_addr_q;
    logic                  pend_valid_q;
    logic                  acc_start_q;
    logic                  tx_valid_q;
    logic [RESULT_WIDTH-1:0] tx_result_q;
    logic                  tx_timeout_q;

    logic [PAYLOAD_W-1:0]  rx_payload;
    job_addr_t             rx_addr;
    logic                  retire;
    logic                  drop_d;

`ifdef INFERENCE_SCHEDULER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_q;
`endif

    assign rx_payload = RX_DATA_FRAME[USER_DATA_BYTES*8-1:8];
    assign rx_addr    = '{ip: RX_SRC_IP, mac: RX_SRC_MAC, tag: RX_DATA_FRAME[7:0]};
    assign retire     = (state_q == WAIT_TX) && tx.TX_DONE;

    // A frame arriving on the retiring edge never drops: the pending slot frees up
    // on that same edge (it moves to active), so the new frame always has a home.
    assign drop_d = RX_FRAME_READY && (state_q != IDLE) && pend_valid_q && !retire;

    // The active slot is occupied exactly when state_q != IDLE, so it needs no flag.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q      <= IDLE;
            act_frame_q  <= '0;
            act_addr_q   <= '0;
            pend_frame_q <= '0;
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
            acc_start_q  <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_result_q  <= '0;
            tx_timeout_q <= 1'b0;
`ifdef INFERENCE_SCHEDULER_TIMEOUT_EN
            wd_q         <= '0;
`endif
        end else begin
            acc_start_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (RX_FRAME_READY) begin
                        act_frame_q <= rx_payload;
                        act_addr_q  <= rx_addr;
                        state_q     <= START_ACC;
                    end
                end

                START_ACC: begin
                    acc_start_q <= 1'b1;
                    state_q     <= WAIT_ACC;
`ifdef INFERENCE_SCHEDULER_TIMEOUT_EN
                    wd_q        <= WD_LOAD;
`endif
                end

                WAIT_ACC: begin
                    if (ACC_DONE) begin
                        tx_result_q  <= ACC_RESULT;
                        tx_timeout_q <= 1'b0;
                        tx_valid_q   <= 1'b1;
                        state_q      <= TX_REQ;
                    end
`ifdef INFERENCE_SCHEDULER_TIMEOUT_EN
                    else if (wd_q == '0) begin
                        tx_result_q  <= '1;
                        tx_timeout_q <= 1'b1;
                        tx_valid_q   <= 1'b1;
                        state_q      <= TX_REQ;
                    end else begin
                        wd_q <= wd_q - 1'b1;
                    end
`endif
                end

                TX_REQ: begin
                    if (tx.TX_READY) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= WAIT_TX;
                    end
                end

                WAIT_TX: begin
                    if (tx.TX_DONE) begin
                        tx_timeout_q <= 1'b0;
                        if (pend_valid_q) begin
                            act_frame_q <= pend_frame_q;
                            act_addr_q  <= pend_addr_q;
                            state_q     <= START_ACC;
                            if (RX_FRAME_READY) begin
                                pend_frame_q <= rx_payload;
                                pend_addr_q  <= rx_addr;
                            end else begin
                                pend_valid_q <= 1'b0;
                            end
                        end else if (RX_FRAME_READY) begin
                            act_frame_q <= rx_payload;
                            act_addr_q  <= rx_addr;
                            state_q     <= START_ACC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Busy with a job that is not retiring: park the frame if there is room.
            if (RX_FRAME_READY && (state_q != IDLE) && !retire && !pend_valid_q) begin
                pend_frame_q <= rx_payload;
                pend_addr_q  <= rx_addr;
                pend_valid_q <= 1'b1;
            end
        end
    end

    sat_counter #(
        .SIZE(16)
    ) u_drop_cnt (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .inc_i  (drop_d),
        .count_o(DROP_COUNT)
    );

    assign ACC_FRAME      = act_frame_q;
    assign ACC_START      = acc_start_q;
    assign BUSY           = (state_q != IDLE);
    assign tx.TX_VALID    = tx_valid_q;
    assign tx.TX_DST_IP   = act_addr_q.ip;
    assign tx.TX_DST_MAC  = act_addr_q.mac;
    assign tx.TX_TAG      = act_addr_q.tag;
    assign tx.TX_RESULT   = tx_result_q;
    assign tx.TX_TIMEOUT  = tx_timeout_q;

endmodule

// File: tb/tb_inference_scheduler.sv
`timescale 1ns/1ps
module tb_inference_scheduler;
    import accel_pkg::*;

    localparam int UDB = 785;
    localparam int RW  = 8;
    localparam int TMO = 16;
    localparam int FW  = UDB * 8;
    localparam int PW  = (UDB - 1) * 8;

    logic           ACLK = 1'b0;
    logic           ARESET = 1'b0;
    logic [FW-1:0]  RX_DATA_FRAME = '0;
    logic [31:0]    RX_SRC_IP = '0;
    logic [47:0]    RX_SRC_MAC = '0;
    logic           RX_FRAME_READY = 1'b0;
    logic [PW-1:0]  ACC_FRAME;
    logic           ACC_START;
    logic           ACC_DONE = 1'b0;
    logic [RW-1:0]  ACC_RESULT = '0;
    logic           BUSY;
    logic [15:0]    DROP_COUNT;

    inference_scheduler_if #(.RESULT_WIDTH(RW)) tx_if ();

    inference_scheduler #(
        .USER_DATA_BYTES(UDB),
        .RESULT_WIDTH   (RW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .RX_DATA_FRAME (RX_DATA_FRAME),
        .RX_SRC_IP     (RX_SRC_IP),
        .RX_SRC_MAC    (RX_SRC_MAC),
        .RX_FRAME_READY(RX_FRAME_READY),
        .ACC_FRAME     (ACC_FRAME),
        .ACC_START     (ACC_START),
        .ACC_DONE      (ACC_DONE),
        .ACC_RESULT    (ACC_RESULT),
        .tx            (tx_if),
        .BUSY          (BUSY),
        .DROP_COUNT    (DROP_COUNT)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Byte n of a frame for tag t is t+n (mod 256), so payload byte 1 is t+1
    // and payload byte 784 is t+0x10.
    function automatic logic [FW-1:0] mk_frame(input logic [7:0] t);
        logic [FW-1:0] f;
        f = '0;
        for (int n = 0; n < UDB; n++) f[8*n +: 8] = t + 8'(n);
        return f;
    endfunction

    task automatic present(input logic [7:0] t, input logic [31:0] ip);
        RX_DATA_FRAME  = mk_frame(t);
        RX_SRC_IP      = ip;
        RX_SRC_MAC     = {16'h0200, ip};
        RX_FRAME_READY = 1'b1;
    endtask

    task automatic send(input logic [7:0] t, input logic [31:0] ip);
        present(t, ip);
        step();
        RX_FRAME_READY = 1'b0;
    endtask

    // Called in the cycle after the job entered START_ACC.
    task automatic expect_start(input logic [7:0] t);
        chk("acc_start_early", 64'(ACC_START), 64'h0);
        step();
        chk("acc_start", 64'(ACC_START), 64'h1);
        chk("acc_frame_lo", 64'(ACC_FRAME[7:0]), 64'(t + 8'h01));
        chk("acc_frame_hi", 64'(ACC_FRAME[PW-1 -: 8]), 64'(t + 8'h10));
        step();
        chk("acc_start_pulse", 64'(ACC_START), 64'h0);
    endtask

    // From WAIT_ACC: finish the accelerator run and the TX handshake; ends in WAIT_TX.
    task automatic complete(input logic [7:0] t, input logic [31:0] ip, input logic [7:0] res);
        ACC_DONE   = 1'b1;
        ACC_RESULT = res;
        step();
        ACC_DONE   = 1'b0;
        chk("tx_valid", 64'(tx_if.TX_VALID), 64'h1);
        chk("tx_tag", 64'(tx_if.TX_TAG), 64'(t));
        chk("tx_ip", 64'(tx_if.TX_DST_IP), 64'(ip));
        chk("tx_result", 64'(tx_if.TX_RESULT), 64'(res));
        chk("tx_timeout", 64'(tx_if.TX_TIMEOUT), 64'h0);
        tx_if.TX_READY = 1'b1;
        step();
        tx_if.TX_READY = 1'b0;
        chk("tx_valid_drop", 64'(tx_if.TX_VALID), 64'h0);
    endtask

    task automatic retire();
        tx_if.TX_DONE = 1'b1;
        step();
        tx_if.TX_DONE = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic seen_valid;
        logic seen_start;
        int   waited;

        tx_if.TX_READY = 1'b0;
        tx_if.TX_DONE  = 1'b0;

        // Reset state
        #2;
        chk("rst_busy", 64'(BUSY), 64'h0);
        chk("rst_acc_start", 64'(ACC_START), 64'h0);
        chk("rst_tx_valid", 64'(tx_if.TX_VALID), 64'h0);
        chk("rst_drop", 64'(DROP_COUNT), 64'h0);
        chk("rst_acc_frame", 64'(ACC_FRAME[63:0]), 64'h0);
        chk("rst_tx_tag", 64'(tx_if.TX_TAG), 64'h0);
        repeat (3) step();

        // Release reset and request on the very first edge afterwards
        ARESET = 1'b1;
        send(8'h2A, 32'h0A000005);
        chk("first_busy", 64'(BUSY), 64'h1);
        expect_start(8'h2A);
        ACC_DONE   = 1'b1;
        ACC_RESULT = 8'h07;
        step();
        ACC_DONE   = 1'b0;
        chk("j1_valid", 64'(tx_if.TX_VALID), 64'h1);
        chk("j1_tag", 64'(tx_if.TX_TAG), 64'h2A);
        chk("j1_ip", 64'(tx_if.TX_DST_IP), 64'h0A000005);
        chk("j1_mac", 64'(tx_if.TX_DST_MAC), 64'h02000A000005);
        chk("j1_result", 64'(tx_if.TX_RESULT), 64'h07);
        chk("j1_timeout", 64'(tx_if.TX_TIMEOUT), 64'h0);

        // TX_READY held low: request and fields must hold
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 64'(tx_if.TX_VALID), 64'h1);
            chk("hold_fields", {tx_if.TX_TAG, tx_if.TX_DST_IP, tx_if.TX_RESULT, 16'h0},
                64'h2A0A000005070000);
        end
        tx_if.TX_READY = 1'b1;
        #1;
        chk("ready_cycle_valid", 64'(tx_if.TX_VALID), 64'h1);
        step();
        tx_if.TX_READY = 1'b0;
        chk("after_ready_valid", 64'(tx_if.TX_VALID), 64'h0);
        chk("wait_tx_busy", 64'(BUSY), 64'h1);
        step();
        chk("wait_tx_busy2", 64'(BUSY), 64'h1);
        retire();
        chk("j1_idle", 64'(BUSY), 64'h0);

        // ACC_DONE outside WAIT_ACC is ignored
        ACC_DONE   = 1'b1;
        ACC_RESULT = 8'h09;
        step();
        ACC_DONE   = 1'b0;
        chk("stray_done_busy", 64'(BUSY), 64'h0);
        chk("stray_done_valid", 64'(tx_if.TX_VALID), 64'h0);
        step();
        chk("stray_done_valid2", 64'(tx_if.TX_VALID), 64'h0);

        // Three frames during one job: second pends, third drops
        send(8'h11, 32'h0A000011);
        expect_start(8'h11);
        send(8'h22, 32'h0A000022);
        chk("pend_no_drop", 64'(DROP_COUNT), 64'h0);
        send(8'h33, 32'h0A000033);
        chk("drop_one", 64'(DROP_COUNT), 64'h1);
        chk("active_kept", 64'(ACC_FRAME[7:0]), 64'h12);
        complete(8'h11, 32'h0A000011, 8'h55);
        retire();
        chk("pend_busy", 64'(BUSY), 64'h1);
        expect_start(8'h22);
        complete(8'h22, 32'h0A000022, 8'h66);
        retire();
        chk("pend_idle", 64'(BUSY), 64'h0);
        chk("drop_still_one", 64'(DROP_COUNT), 64'h1);

        // RX coincident with retiring TX_DONE, pending full
        send(8'h44, 32'h0A000044);
        expect_start(8'h44);
        send(8'h45, 32'h0A000045);
        complete(8'h44, 32'h0A000044, 8'h01);
        tx_if.TX_DONE = 1'b1;
        present(8'h46, 32'h0A000046);
        step();
        tx_if.TX_DONE  = 1'b0;
        RX_FRAME_READY = 1'b0;
        chk("coinc_full_drop", 64'(DROP_COUNT), 64'h1);
        chk("coinc_full_busy", 64'(BUSY), 64'h1);
        expect_start(8'h45);
        complete(8'h45, 32'h0A000045, 8'h02);
        retire();
        expect_start(8'h46);
        complete(8'h46, 32'h0A000046, 8'h03);
        retire();
        chk("coinc_full_idle", 64'(BUSY), 64'h0);

        // RX coincident with retiring TX_DONE, pending empty
        send(8'h50, 32'h0A000050);
        expect_start(8'h50);
        complete(8'h50, 32'h0A000050, 8'h04);
        tx_if.TX_DONE = 1'b1;
        present(8'h51, 32'h0A000051);
        step();
        tx_if.TX_DONE  = 1'b0;
        RX_FRAME_READY = 1'b0;
        chk("coinc_empty_busy", 64'(BUSY), 64'h1);
        expect_start(8'h51);
        complete(8'h51, 32'h0A000051, 8'h05);
        retire();
        chk("coinc_empty_idle", 64'(BUSY), 64'h0);
        chk("coinc_drop", 64'(DROP_COUNT), 64'h1);

        // Reset in WAIT_ACC abandons the job
        send(8'h77, 32'h0A000077);
        expect_start(8'h77);
        #2;
        ARESET = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(BUSY), 64'h0);
        chk("mid_rst_acc_start", 64'(ACC_START), 64'h0);
        chk("mid_rst_valid", 64'(tx_if.TX_VALID), 64'h0);
        chk("mid_rst_drop", 64'(DROP_COUNT), 64'h0);
        chk("mid_rst_frame", 64'(ACC_FRAME[63:0]), 64'h0);
        chk("mid_rst_tag", 64'(tx_if.TX_TAG), 64'h0);
        chk("mid_rst_ip", 64'(tx_if.TX_DST_IP), 64'h0);
        chk("mid_rst_result", 64'(tx_if.TX_RESULT), 64'h0);
        @(negedge ACLK);
        ARESET = 1'b1;
        step();
        ACC_DONE   = 1'b1;
        ACC_RESULT = 8'hAA;
        step();
        ACC_DONE   = 1'b0;
        seen_valid = tx_if.TX_VALID;
        seen_start = ACC_START;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_valid = seen_valid | tx_if.TX_VALID;
            seen_start = seen_start | ACC_START;
        end
        chk("post_rst_no_valid", 64'(seen_valid), 64'h0);
        chk("post_rst_no_start", 64'(seen_start), 64'h0);
        chk("post_rst_idle", 64'(BUSY), 64'h0);

`ifdef INFERENCE_SCHEDULER_TIMEOUT_EN
        // Watchdog: no ACC_DONE, timed-out response after TMO cycles in WAIT_ACC
        send(8'h5A, 32'h0A00005A);
        expect_start(8'h5A);
        waited = 1;
        while (!tx_if.TX_VALID && waited < 40) begin
            step();
            waited++;
        end
        chk("wd_latency", 64'(waited), 64'(TMO));
        chk("wd_valid", 64'(tx_if.TX_VALID), 64'h1);
        chk("wd_timeout", 64'(tx_if.TX_TIMEOUT), 64'h1);
        chk("wd_result", 64'(tx_if.TX_RESULT), 64'hFF);
        chk("wd_tag", 64'(tx_if.TX_TAG), 64'h5A);
        tx_if.TX_READY = 1'b1;
        step();
        tx_if.TX_READY = 1'b0;
        retire();
        chk("wd_idle", 64'(BUSY), 64'h0);
        chk("wd_timeout_clr", 64'(tx_if.TX_TIMEOUT), 64'h0);
`else
        // No watchdog: WAIT_ACC waits indefinitely
        send(8'h5A, 32'h0A00005A);
        expect_start(8'h5A);
        waited = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tx_if.TX_VALID) waited++;
        end
        chk("nowd_no_valid", 64'(waited), 64'h0);
        chk("nowd_busy", 64'(BUSY), 64'h1);
        chk("nowd_timeout", 64'(tx_if.TX_TIMEOUT), 64'h0);
        complete(8'h5A, 32'h0A00005A, 8'h3C);
        retire();
        chk("nowd_idle", 64'(BUSY), 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
